aes_128_key_expand: RTL and testbench

//  AES-128 key schedule generator, directly upstream of aes_128_keyram.
//  - Takes a 128-bit cipher key and computes round keys 0..10 on the fly, one round per state-machine pass.
//  - Writes each round key into the key RAM as two 64-bit words on en_wr/key_round_wr.
//  - Once all 11 round keys are stored, the RAM can serve encryption rounds via key_ready.
//  - Self-contained: S-box is an in-file combinational function (composite-field GF((2^4)^2) inverse + affine). No BRAM.

---
 rtl/aes_128_key_expand.sv | 159 +++++++++++++++
 tb/tb_aes_128_key_expand.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_key_expand.sv
// AES-128 key schedule: expands a cipher key into round keys 0..10 and streams each one as two 64-bit halves.
// Build option AES_KEYEXP_WR_GAP_EN inserts an idle cycle between the two halves of every round key.
module aes_128_key_expand #(
    parameter int NR       = 10,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         done,
    output logic         en_wr,
    output logic [63:0]  key_round_wr
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [2:0] {IDLE, WR_A, GAP, WR_B, CALC, DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] rk, rk_next;
    logic [3:0]   rnd;
    logic         load_acc, step_key;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = xtime(s);
        end
        return p;
    endfunction

    // Inversion through the GF(2^4) subfield: a^-1 = a^16 * (a^17)^-1, where a^17 lies in GF(2^4)
    // and its inverse there is (a^17)^14. Zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a4, a8, a16, n, n2, n4, n8, n14;
        a2  = gf_mul(a, a);
        a4  = gf_mul(a2, a2);
        a8  = gf_mul(a4, a4);
        a16 = gf_mul(a8, a8);
        n   = gf_mul(a16, a);
        n2  = gf_mul(n, n);
        n4  = gf_mul(n2, n2);
        n8  = gf_mul(n4, n4);
        n14 = gf_mul(gf_mul(n8, n4), n2);
        return gf_mul(a16, n14);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(r + 4'd1), 24'h0};
        n0  = w0 ^ t;
        n1  = n0 ^ w1;
        n2  = n1 ^ w2;
        n3  = n2 ^ w3;
        return {n0, n1, n2, n3};
    endfunction

    assign rk_next = key_step(rk, rnd);

    always_ff @(posedge clk) begin
        if (kill) begin
            state <= IDLE;
            rnd   <= 4'd0;
            rk    <= 128'h0;
        end else begin
            state <= state_nxt;
            if (load_acc) begin
                rk  <= key_in;
                rnd <= 4'd0;
            end else if (step_key) begin
                rk  <= rk_next;
                rnd <= rnd + 4'd1;
            end
        end
    end

    // The last round skips CALC so done follows the final write directly.
    always_comb begin
        state_nxt    = state;
        load_acc     = 1'b0;
        step_key     = 1'b0;
        en_wr        = 1'b0;
        done         = 1'b0;
        key_round_wr = 64'h0;
        case (state)
            IDLE: begin
                if (key_load) begin
                    load_acc  = 1'b1;
                    state_nxt = WR_A;
                end
            end
            WR_A: begin
                en_wr        = 1'b1;
                key_round_wr = HI_FIRST ? rk[127:64] : rk[63:0];
`ifdef AES_KEYEXP_WR_GAP_EN
                state_nxt    = GAP;
`else
                state_nxt    = WR_B;
`endif
            end
            GAP:  state_nxt = WR_B;
            WR_B: begin
                en_wr        = 1'b1;
                key_round_wr = HI_FIRST ? rk[63:0] : rk[127:64];
                state_nxt    = (rnd == LAST_RND) ? DONE : CALC;
            end
            CALC: begin
                if (rnd < LAST_RND) begin
                    step_key  = 1'b1;
                    state_nxt = WR_A;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Self-checking bench for aes_128_key_expand: FIPS-197 key schedule model, per-cycle output checks, random keys.
`timescale 1ns/1ps
module tb_aes_128_key_expand;

    logic         clk = 1'b0;
    logic         kill;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy, done, en_wr;
    logic [63:0]  key_round_wr;

`ifdef AES_KEYEXP_WR_GAP_EN
    localparam int P        = 4;
    localparam int DONE_LIT = 44;
`else
    localparam int P        = 3;
    localparam int DONE_LIT = 33;
`endif
    localparam int DONE_CYC = 11 * P;

    aes_128_key_expand dut (
        .clk          (clk),
        .kill         (kill),
        .key_in       (key_in),
        .key_load     (key_load),
        .busy         (busy),
        .done         (done),
        .en_wr        (en_wr),
        .key_round_wr (key_round_wr)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk_m [0:10];
    int           m_cyc = -1;
    int           npulse = 0;
    int           done_at = -1;
    bit           done_seen = 1'b0;
    logic [63:0]  words [$];
    logic [63:0]  t1_words [$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_m[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic        e_busy, e_done, e_en;
        logic [63:0] e_word;
        int          ph, r;
        e_busy = (m_cyc >= 1);
        e_done = (m_cyc == DONE_CYC);
        e_en   = 1'b0;
        e_word = 64'h0;
        if (m_cyc >= 1 && m_cyc < DONE_CYC) begin
            ph = (m_cyc - 1) % P;
            r  = (m_cyc - 1) / P;
            if (ph == 0) begin
                e_en = 1'b1; e_word = rk_m[r][127:64];
            end else if (ph == P - 2) begin
                e_en = 1'b1; e_word = rk_m[r][63:0];
            end
        end
        chk("busy", 128'(busy), 128'(e_busy));
        chk("done", 128'(done), 128'(e_done));
        chk("en_wr", 128'(en_wr), 128'(e_en));
        chk("key_round_wr", 128'(key_round_wr), 128'(e_word));
        if (en_wr === 1'b1) begin
            npulse++;
            words.push_back(key_round_wr);
        end
        if (done === 1'b1) begin
            done_seen = 1'b1;
            done_at   = m_cyc;
        end
    endtask

    // One clock: advance the reference timeline with the inputs of this cycle, then check outputs.
    task automatic tick();
        @(posedge clk);
        if (kill) m_cyc = -1;
        else if (m_cyc < 0) begin
            if (key_load) begin
                m_cyc = 1;
                expand(key_in);
                npulse = 0; words.delete(); done_at = -1; done_seen = 1'b0;
            end
        end else begin
            m_cyc++;
            if (m_cyc > DONE_CYC) m_cyc = -1;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic run_load(input logic [127:0] k, input int repulse_at, input int kill_at);
        key_in = k; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 60 && m_cyc >= 0; i++) begin
            if (m_cyc == repulse_at) begin key_load = 1'b1; key_in = '1; end
            if (m_cyc == kill_at) kill = 1'b1;
            tick();
            key_load = 1'b0; kill = 1'b0;
            key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        chk("idle_after_run", 128'(busy), 128'd0);
    endtask

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        kill = 1'b1; key_load = 1'b0; key_in = 128'h0;
        build_sbox();
        for (int i = 0; i < 3; i++) tick();
        kill = 1'b0;
        tick();

        // T1: FIPS-197 key
        run_load(K1, -1, -1);
        chk("t1_model_rk0", rk_m[0], K1);
        chk("t1_model_rk10", rk_m[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("t1_pulses", 128'(npulse), 128'd22);
        chk("t1_word1", 128'(words[0]), 128'h2b7e151628aed2a6);
        chk("t1_word3", 128'(words[2]), 128'ha0fafe1788542cb1);
        chk("t1_word22", 128'(words[21]), 128'he13f0cc8b6630ca6);
        chk("t1_done_cycle", 128'(done_at), 128'(DONE_LIT));
        t1_words = words;

        // T2: zero key
        run_load(128'h0, -1, -1);
        chk("t2_model_rk1", rk_m[1], 128'h62636363626363636263636362636363);
        chk("t2_model_rk10", rk_m[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        chk("t2_round1", {words[2], words[3]}, 128'h62636363626363636263636362636363);
        chk("t2_round10", {words[20], words[21]}, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // T3: re-pulse while busy is ignored
        run_load(K1, 10, -1);
        chk("t3_pulses", 128'(npulse), 128'd22);
        for (int i = 0; i < 22; i++) chk("t3_same_as_t1", 128'(words[i]), 128'(t1_words[i]));

        // T4: abort mid-expansion, then a clean zero-key run
        run_load(K1, -1, 20);
        chk("t4_no_done", 128'(done_seen), 128'd0);
        for (int i = 0; i < 10; i++) tick();
        run_load(128'h0, -1, -1);
        chk("t4_pulses", 128'(npulse), 128'd22);
        chk("t4_round10", {words[20], words[21]}, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // T5: kill and key_load together, kill wins
        npulse = 0;
        kill = 1'b1; key_load = 1'b1; key_in = 128'h0123456789abcdef0123456789abcdef;
        tick();
        kill = 1'b0; key_load = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk("t5_no_writes", 128'(npulse), 128'd0);

        // Random keys, random ignored re-pulses (including the done cycle), occasional abort
        for (int n = 0; n < 8; n++) begin
            int rp, kl;
            rp = int'($urandom_range(DONE_CYC, 1));
            kl = ($urandom_range(2, 0) == 0) ? int'($urandom_range(DONE_CYC - 1, 2)) : -1;
            run_load({$urandom(), $urandom(), $urandom(), $urandom()}, rp, kl);
            if (kl < 0) chk("rand_pulses", 128'(npulse), 128'd22);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
